// File: rtl/hash_feeder_pkg.sv
// Shared types and defaults for the hash core message feeder.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package hash_feeder_pkg;

    localparam int LEN_W_DEF          = 64;
    localparam int DIGEST_W           = 32;
    localparam int BYTE_GAP_DEF       = 6;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    // One message walks IDLE -> LOAD -> DRIVE -> GAP -> (LOAD | WAIT) -> OUT -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_GAP   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } feeder_state_t;

    // Bits needed by the shared down-counter to hold max(gap, timeout) - 1.
    function automatic int timer_width(input int gap, input int timeout);
        int top_val;
        top_val = (gap > timeout) ? gap : timeout;
        return (top_val <= 2) ? 1 : $clog2(top_val);
    endfunction

endpackage

// File: rtl/hash_feeder_gap_timer.sv
// Loadable down-counter with zero / one flags, shared by byte pacing and the completion watchdog.
// Latency: load takes effect on the next edge; flags are combinational from the count.
// Backpressure: none; decrements only while dec is high and stops at zero.
module hash_feeder_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt;

    // Load has priority over counting; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/hash_msg_feeder.sv
// Feeds a length-prefixed host byte stream into the hash core and returns the 32-bit digest.
// Latency: accepted byte strobes the core 1 cycle later; strobes spaced max(BYTE_GAP, 3) cycles.
// Backpressure: in_ready_o only in LOAD; digest held until digest_ready_i. Optional watchdog: HASH_FEEDER_TIMEOUT_EN.
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int BYTE_GAP = BYTE_GAP_DEF,
    parameter int LEN_W    = LEN_W_DEF
`ifdef HASH_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    // host command
    input  logic                start_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    // host byte stream
    input  logic [7:0]          in_byte_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    // host digest return
    output logic [DIGEST_W-1:0] digest_o,
    output logic                digest_valid_o,
    input  logic                digest_ready_i,
    output logic                err_o,
    // hash core side
    output logic [7:0]          hs_message_o,
    output logic                hs_m_valid_o,
    output logic [LEN_W-1:0]    hs_counter_o,
    input  logic                hs_hash_ready_i,
    input  logic [DIGEST_W-1:0] hs_digest_i
);

`ifdef HASH_FEEDER_TIMEOUT_EN
    localparam int TW = timer_width(BYTE_GAP, TIMEOUT_CYCLES);
`else
    localparam int TW = timer_width(BYTE_GAP, 1);
`endif

    feeder_state_t  state;
    logic [LEN_W-1:0] remaining;
    logic           rdy_q;
    logic           done_pend;
    logic           xfer;
    logic           rise;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_dec;
    logic           tmr_zero;
    logic           tmr_one;
    logic           gap_done;

    assign xfer = in_valid_i & in_ready_o;
    // Completion is the 0->1 edge only: a level left high by the previous message means nothing.
    assign rise = hs_hash_ready_i & ~rdy_q;
    // The timer is loaded as the byte is accepted, so it already counts during DRIVE; leaving GAP
    // at one lets the LOAD + DRIVE cycles land the next strobe exactly BYTE_GAP after this one.
    assign gap_done = tmr_zero | tmr_one;

    // Timer control: byte pacing, plus the completion watchdog when it is built in.
    always_comb begin
        tmr_load = xfer;
        tmr_val  = TW'(BYTE_GAP - 1);
        tmr_dec  = (state == ST_DRIVE) || (state == ST_GAP);
`ifdef HASH_FEEDER_TIMEOUT_EN
        if ((state == ST_GAP) && gap_done && (remaining == '0)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        end
        if (state == ST_WAIT) begin
            tmr_dec = 1'b1;
        end
`endif
    end

    hash_feeder_gap_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    // Previous-cycle copy of the core completion flag for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= hs_hash_ready_i;
        end
    end

    // Message sequencer with all host and core outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            remaining      <= '0;
            done_pend      <= 1'b0;
            busy_o         <= 1'b0;
            in_ready_o     <= 1'b0;
            digest_o       <= '0;
            digest_valid_o <= 1'b0;
            err_o          <= 1'b0;
            hs_message_o   <= '0;
            hs_m_valid_o   <= 1'b0;
            hs_counter_o   <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            hs_counter_o <= len_i;
                            remaining    <= len_i;
                            busy_o       <= 1'b1;
                            in_ready_o   <= 1'b1;
                            done_pend    <= 1'b0;
                            state        <= ST_LOAD;
                        end else begin
                            // The core cannot hash an empty message.
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        hs_message_o <= in_byte_i;
                        hs_m_valid_o <= 1'b1;
                        in_ready_o   <= 1'b0;
                        state        <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    hs_m_valid_o <= 1'b0;
                    if (remaining != '0) begin
                        remaining <= remaining - LEN_W'(1);
                    end
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    // A fast core may finish the last byte before WAIT; remember it.
                    if ((remaining == '0) && rise) begin
                        digest_o  <= hs_digest_i;
                        done_pend <= 1'b1;
                    end
                    if (gap_done) begin
                        if (remaining != '0) begin
                            in_ready_o <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rise || done_pend) begin
                        if (rise) begin
                            digest_o <= hs_digest_i;
                        end
                        digest_valid_o <= 1'b1;
                        done_pend      <= 1'b0;
                        state          <= ST_OUT;
                    end
`ifdef HASH_FEEDER_TIMEOUT_EN
                    else if (tmr_zero) begin
                        err_o        <= 1'b1;
                        busy_o       <= 1'b0;
                        hs_counter_o <= '0;
                        state        <= ST_IDLE;
                    end
`endif
                end
                ST_OUT: begin
                    // valid is registered, so a ready seen as it rises is honoured a cycle later
                    if (digest_ready_i) begin
                        digest_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        hs_counter_o   <= '0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a port-level transaction model checked every cycle.
// Latency: n/a.
// Backpressure: the host drives bytes back to back; digest_ready_i is held off in one scenario.
module tb_hash_msg_feeder;

    localparam int BYTE_GAP = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] len_i = '0;
    logic        busy_o;
    logic [7:0]  in_byte_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] digest_o;
    logic        digest_valid_o;
    logic        digest_ready_i = 1'b0;
    logic        err_o;
    logic [7:0]  hs_message_o;
    logic        hs_m_valid_o;
    logic [63:0] hs_counter_o;
    logic        hs_hash_ready_i = 1'b0;
    logic [31:0] hs_digest_i = '0;

    int checks = 0;
    int errors = 0;

    hash_msg_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .in_byte_i       (in_byte_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .digest_o        (digest_o),
        .digest_valid_o  (digest_valid_o),
        .digest_ready_i  (digest_ready_i),
        .err_o           (err_o),
        .hs_message_o    (hs_message_o),
        .hs_m_valid_o    (hs_m_valid_o),
        .hs_counter_o    (hs_counter_o),
        .hs_hash_ready_i (hs_hash_ready_i),
        .hs_digest_i     (hs_digest_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    logic        m_busy, m_err_exp, m_pulse_exp, m_dvld, m_armed, m_rdy_prev;
    logic [63:0] m_len;
    logic [7:0]  m_byte;
    logic [31:0] m_digest;
    int          m_acc, m_pidx, m_last, cyc;
    int          pulse_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  plog_byte[$];
    int          plog_cyc[$];
    logic [63:0] plog_ctr[$];

    task automatic model_reset();
        m_busy = 0; m_err_exp = 0; m_pulse_exp = 0; m_dvld = 0; m_armed = 0; m_rdy_prev = 0;
        m_len = '0; m_byte = '0; m_digest = '0; m_acc = 0; m_pidx = 0; m_last = 0;
    endtask

    initial begin
        model_reset();
        cyc = 0;
    end

    // Compare outputs of the current cycle, then advance the model on what the DUT will sample.
    always @(negedge clk) begin
        logic nxt_pulse;
        if (rst) model_reset();
        chk("busy", busy_o, m_busy);
        chk("err", err_o, m_err_exp);
        chk("m_valid", hs_m_valid_o, m_pulse_exp);
        chk("counter", hs_counter_o, m_busy ? m_len : 64'd0);
        chk("digest_valid", digest_valid_o, m_dvld);
        if (m_dvld) chk("digest", digest_o, m_digest);
        if (in_ready_o) chk("in_ready_legal", (m_busy && (m_acc < int'(m_len)) && !m_pulse_exp), 1);
        if (m_pulse_exp) begin
            chk("message", hs_message_o, m_byte);
            if (m_pidx > 0) chk("byte_spacing", cyc - m_last, BYTE_GAP);
        end
        if (hs_m_valid_o) begin
            pulse_cnt++;
            plog_byte.push_back(hs_message_o);
            plog_cyc.push_back(cyc);
            plog_ctr.push_back(hs_counter_o);
        end
        if (err_o) err_cnt++;
        if (!rst) begin
            nxt_pulse = in_valid_i && in_ready_o;
            if (nxt_pulse) begin
                m_byte = in_byte_i;
                m_acc++;
            end
            if (m_pulse_exp) begin
                m_pidx++;
                m_last = cyc;
                if (m_pidx == int'(m_len)) m_armed = 1;
            end
            m_err_exp = 0;
            if (!m_busy && start_i) begin
                if (len_i == 0) m_err_exp = 1;
                else begin
                    m_busy = 1; m_len = len_i; m_acc = 0; m_pidx = 0; m_armed = 0;
                end
            end
            if (m_dvld && digest_ready_i) begin
                m_dvld = 0; m_busy = 0; m_len = '0;
            end
            if (m_armed && hs_hash_ready_i && !m_rdy_prev) begin
                m_dvld = 1; m_digest = hs_digest_i; m_armed = 0;
            end
            m_pulse_exp = nxt_pulse;
            m_rdy_prev  = hs_hash_ready_i;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        in_valid_i = 1'b1;
        in_byte_i  = b;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (in_ready_o) got = 1;
        end
        chk("byte_accepted", got, 1);
        tick();
    endtask

    task automatic wait_pulses(input int target);
        for (int n = 0; n < 200 && pulse_cnt < target; n++) @(negedge clk);
        chk("pulses_reached", pulse_cnt >= target, 1);
    endtask

    task automatic wait_dvld();
        bit got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (digest_valid_o) got = 1;
        end
        chk("digest_valid_seen", got, 1);
    endtask

    task automatic run_msg(input int len, input logic [31:0] bytes_w, input int rise_dly,
                           input logic [31:0] dig, input bit stuck, input int hold, output int np);
        int p0;
        logic [31:0] bw;
        p0 = pulse_cnt;
        bw = bytes_w;
        if (!stuck) hs_hash_ready_i = 1'b0;
        start_i = 1'b1;
        len_i   = 64'(len);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        for (int i = 0; i < len; i++) send_byte(bw[8*i +: 8]);
        in_valid_i = 1'b0;
        wait_pulses(p0 + len);
        if (stuck) begin
            repeat (15) tick();
            chk("stale_level_ignored", digest_valid_o, 0);
            hs_hash_ready_i = 1'b0;
            tick();
        end
        repeat (rise_dly) tick();
        hs_digest_i     = dig;
        hs_hash_ready_i = 1'b1;
        wait_dvld();
        chk("digest_literal", digest_o, dig);
        for (int i = 0; i < hold; i++) begin
            tick();
            start_i = (i == 3);
            len_i   = (i == 3) ? 64'd5 : 64'd0;
        end
        start_i = 1'b0;
        len_i   = '0;
        if (hold > 0) begin
            chk("held_valid", digest_valid_o, 1);
            chk("held_digest", digest_o, dig);
            chk("held_busy", busy_o, 1);
        end
        tick();
        digest_ready_i = 1'b1;
        tick();
        digest_ready_i = 1'b0;
        repeat (2) tick();
        chk("idle_after_handoff", busy_o, 0);
        np = pulse_cnt - p0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int np, e0, p0;
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_digest_valid", digest_valid_o, 0);
        chk("rst_digest", digest_o, 0);
        chk("rst_counter", hs_counter_o, 0);
        chk("rst_m_valid", hs_m_valid_o, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // single byte 0x61, core completes 20 cycles later
        run_msg(1, 32'h0000_0061, 20, 32'hDEAD_BEEF, 0, 0, np);
        chk("t1_pulses", np, 1);
        chk("t1_byte", plog_byte[plog_byte.size()-1], 8'h61);

        // three bytes back to back
        plog_byte.delete(); plog_cyc.delete(); plog_ctr.delete();
        run_msg(3, 32'h0043_4241, 12, 32'h1234_5678, 0, 0, np);
        chk("t2_pulses", np, 3);
        if (plog_byte.size() == 3) begin
            chk("t2_b0", plog_byte[0], 8'h41);
            chk("t2_b1", plog_byte[1], 8'h42);
            chk("t2_b2", plog_byte[2], 8'h43);
            chk("t2_gap01", plog_cyc[1] - plog_cyc[0], 6);
            chk("t2_gap12", plog_cyc[2] - plog_cyc[1], 6);
            chk("t2_ctr0", plog_ctr[0], 3);
            chk("t2_ctr2", plog_ctr[2], 3);
        end

        // zero-length start
        e0 = err_cnt;
        p0 = pulse_cnt;
        start_i = 1'b1;
        len_i   = '0;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_busy", busy_o, 0);
        chk("t3_no_pulse", pulse_cnt - p0, 0);

        // core ready still high from the previous message
        run_msg(2, 32'h0000_7172, 5, 32'hCAFE_F00D, 1, 0, np);
        chk("t4_pulses", np, 2);

        // host holds off the digest for 10 cycles, start during hold ignored
        run_msg(1, 32'h0000_0033, 10, 32'hA5A5_0F0F, 0, 10, np);
        chk("t5_pulses", np, 1);

        // reset after the first of four bytes
        hs_hash_ready_i = 1'b0;
        p0 = pulse_cnt;
        start_i = 1'b1;
        len_i   = 64'd4;
        tick();
        start_i = 1'b0;
        len_i   = '0;
        send_byte(8'h11);
        in_valid_i = 1'b0;
        wait_pulses(p0 + 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_counter", hs_counter_o, 0);
        chk("mid_rst_in_ready", in_ready_o, 0);
        chk("mid_rst_m_valid", hs_m_valid_o, 0);
        chk("mid_rst_message", hs_message_o, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        run_msg(1, 32'h0000_007E, 10, 32'h0BAD_C0DE, 0, 0, np);
        chk("t6_pulses", np, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
